readout_ctrl: RTL and testbench

Host-side readout sequencer sitting directly downstream of the 16k-deep capture buffer. On a host start command it issues read strobes to the buffer, compensates for the buffer's fixed read latency, and delivers exactly the requested number of 16-bit samples on a valid/ready stream. A small skid FIFO absorbs in-flight reads when the host stalls, so no sample is lost or duplicated. Runs entirely in the buffer's read clock domain.

---
 rtl/readout_ctrl_if.sv | 30 +++
 rtl/readout_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_readout_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_ctrl_if.sv
// readout_ctrl_if: bundles the start/status, buffer-read and output-stream
// signals of readout_ctrl.
//   master : environment side (host command, buffer model, stream sink)
//   slave  : readout_ctrl side
// Signals: start, len (burst request); rdy, rden, din (capture buffer read);
//          m_data, m_valid, m_ready (sample stream); busy, done (status).
interface readout_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic [CNT_W-1:0] len;
  logic             rdy;
  logic             rden;
  logic [15:0]      din;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, len, rdy, din, m_ready,
    input  rden, m_data, m_valid, busy, done
  );

  modport slave (
    input  start, len, rdy, din, m_ready,
    output rden, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/readout_ctrl.sv
// readout_ctrl: host-side readout sequencer for the capture buffer.
// On start (len != 0) it issues len read strobes to the buffer, tracks the
// RD_LAT-cycle read latency with a shift register, catches returning data in
// a small skid FIFO and streams the samples out on a valid/ready port.
// Reads are credited against the skid FIFO so a stalled host never causes
// an overflow or a lost sample.
// Ports:
//   rclk          read clock, rising edge
//   rst           asynchronous active-low reset
//   bus.start/len burst request, sampled in IDLE only
//   bus.rdy       buffer ready; rden is gated by it
//   bus.rden      read strobe, one sample per high cycle
//   bus.din       buffer data, valid RD_LAT cycles after rden
//   bus.m_data/m_valid/m_ready  output sample stream
//   bus.busy      burst in progress
//   bus.done      one-cycle pulse after the final beat
// Build option: define READOUT_CHKSUM_EN to append a 16-bit sum of all
// delivered samples as one extra beat before done.
module readout_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic          rclk,
  input  logic          rst,
  readout_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(SKID_DEPTH) + 1;
  localparam int unsigned CRD_W = OCC_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
`ifdef READOUT_CHKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued;
  logic [RD_LAT-1:0] rd_pipe;
  logic [15:0]      skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] skid_cnt;
  logic [OCC_W-1:0] inflight;
  logic [CRD_W-1:0] credit;
  logic             start_ok;
  logic             rden_c;
  logic             skid_wr;
  logic             skid_rd;
  logic             drain_done;
  logic             busy_q;
  logic             done_q;
`ifdef READOUT_CHKSUM_EN
  logic [15:0]      sum_q;
`endif

  // Reads still in the latency pipe; they already own a skid slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(rd_pipe[i]);
    end
  end

  // Datapath handshakes and read credit.
  always_comb begin
    credit     = CRD_W'(inflight) + CRD_W'(skid_cnt);
    start_ok   = (state == S_IDLE) && bus.start && (bus.len != '0);
    rden_c     = (state == S_RUN) && bus.rdy && (issued != len_q) &&
                 (credit < CRD_W'(SKID_DEPTH));
    skid_wr    = rd_pipe[RD_LAT-1];
    skid_rd    = (skid_cnt != '0) && bus.m_ready;
    // Last sample leaves the skid this cycle (or already has).
    drain_done = (rd_pipe == '0) &&
                 ((skid_cnt == '0) || ((skid_cnt == OCC_W'(1)) && skid_rd));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (issued == len_q) state_nxt = S_DRAIN;
`ifdef READOUT_CHKSUM_EN
      S_DRAIN: if (drain_done) state_nxt = S_CHK;
      S_CHK:   if (bus.m_ready) state_nxt = S_DONE;
`else
      S_DRAIN: if (drain_done) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, status flags and burst bookkeeping.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      len_q  <= '0;
      issued <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
      done_q <= (state_nxt == S_DONE);
      if (start_ok) begin
        len_q  <= bus.len;
        issued <= '0;
      end else if (rden_c) begin
        issued <= issued + CNT_W'(1);
      end
    end
  end

  // Read-latency tracker: the tail bit marks din valid this cycle.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      rd_pipe <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_pipe[0] <= rden_c;
    end
  end

  // Skid FIFO; the head entry drives the output stream directly.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
    end else begin
      if (skid_wr) begin
        skid_mem[wr_ptr] <= bus.din;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (skid_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({skid_wr, skid_rd})
        2'b10:   skid_cnt <= skid_cnt + OCC_W'(1);
        2'b01:   skid_cnt <= skid_cnt - OCC_W'(1);
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

`ifdef READOUT_CHKSUM_EN
  // Running sum of every sample word handed to the host.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (skid_rd) begin
      sum_q <= sum_q + skid_mem[rd_ptr];
    end
  end

  assign bus.m_valid = (skid_cnt != '0) || (state == S_CHK);
  assign bus.m_data  = (state == S_CHK) ? sum_q : skid_mem[rd_ptr];
`else
  assign bus.m_valid = (skid_cnt != '0);
  assign bus.m_data  = skid_mem[rd_ptr];
`endif

  // rden must react to rdy and to the credit limit in the same cycle.
  assign bus.rden = rden_c;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_readout_ctrl.sv
// tb_readout_ctrl: self-checking bench for readout_ctrl. A behavioural
// capture-buffer model feeds din; every accepted beat is checked against a
// queue of the samples the buffer handed out (plus the sum beat when
// READOUT_CHKSUM_EN is defined).
`timescale 1ns/1ps
module tb_readout_ctrl;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned SKID_DEPTH = 4;

  logic rclk = 1'b0;
  logic rst;

  readout_ctrl_if #(.CNT_W(CNT_W)) bus ();

  readout_ctrl #(
    .CNT_W(CNT_W), .RD_LAT(RD_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .rclk(rclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 rclk = ~rclk;

  // Capture buffer model: sample n of the stream appears RD_LAT cycles
  // after the n-th rden.
  logic [15:0] src [256];
  int unsigned src_idx;
  logic [15:0] lat_pipe [RD_LAT];

  always @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) lat_pipe[i] <= 16'h0000;
      src_idx <= 0;
    end else begin
      lat_pipe[0] <= bus.rden ? src[8'(src_idx)] : 16'hDEAD;
      for (int i = 1; i < RD_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
      if (bus.rden) src_idx <= src_idx + 1;
    end
  end
  assign bus.din = lat_pipe[RD_LAT-1];

  int n_vec;
  int n_err;
  int n_rden;
  int n_done;
  int n_beats;
  logic [15:0] exp_q [$];
  logic [15:0] last_beat;
  logic [15:0] prev_data;
  logic        prev_stall;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        rden;
    logic        m_valid;
    logic        busy;
    logic        done;
    logic        chk_data;
    logic [15:0] m_data;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor and scoreboard.
  task automatic observe();
    if (bus.rden) begin
      n_rden++;
      chk("rden_gated_by_rdy", 32'(bus.rdy), 32'd1);
    end
    if (bus.done) n_done++;
    if (prev_stall) begin
      chk("stall_valid_held", 32'(bus.m_valid), 32'd1);
      chk("stall_data_held", 32'(bus.m_data), 32'(prev_data));
    end
    if (bus.m_valid && bus.m_ready) begin
      n_beats++;
      last_beat = bus.m_data;
      if (exp_q.size() == 0) chk("beat_expected", 32'd0, 32'd1);
      else chk("beat_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
    if (dut.skid_wr) chk("skid_no_overflow", 32'(dut.skid_cnt >= SKID_DEPTH), 32'd0);
    prev_stall = bus.m_valid & ~bus.m_ready;
    prev_data  = bus.m_data;
  endtask

  // Inputs are set right after a falling edge; outputs sampled 1ns later.
  task automatic step();
    #1;
    observe();
    @(negedge rclk);
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {28'd0, bus.busy, bus.done, bus.rden, bus.m_valid}, 32'd0);
  endtask

  // Load the buffer with len samples and the expected output stream.
  task automatic load_burst(input int len, input int mode);
    logic [15:0] v;
    logic [15:0] sum;
    logic [15:0] fixed [3];
    fixed[0] = 16'hFFFF; fixed[1] = 16'h0002; fixed[2] = 16'h0010;
    sum = 16'h0000;
    for (int i = 0; i < len; i++) begin
      if (mode == 5) v = fixed[i % 3];
      else if (mode == 0) v = 16'h0100 + 16'(i);
      else v = 16'($urandom);
      src[8'(src_idx + 32'(i))] = v;
      exp_q.push_back(v);
      sum = sum + v;
    end
`ifdef READOUT_CHKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  // mode 0 all ready, 1 host stall 5..14, 2 buffer not ready 3..6,
  // 3 random, 4 random with stray start commands, 5 fixed checksum data.
  task automatic run_burst(input int len, input int mode);
    int cyc;
    int budget;
    int beats0;
    load_burst(len, mode);
    n_rden = 0;
    n_done = 0;
    beats0 = n_beats;
    bus.start = 1'b1; bus.len = 16'(len); bus.rdy = 1'b1; bus.m_ready = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    budget = 40 * len + 100;
    while (n_done == 0 && cyc < budget) begin
      case (mode)
        1: bus.m_ready = !(cyc >= 5 && cyc <= 14);
        2: bus.rdy     = !(cyc >= 3 && cyc <= 6);
        3, 4: begin
          bus.rdy     = ($urandom_range(0, 3) != 0);
          bus.m_ready = ($urandom_range(0, 2) != 0);
        end
        default: ;
      endcase
      if (mode == 4) begin
        bus.start = ($urandom_range(0, 7) == 0);
        bus.len   = 16'($urandom_range(1, 60));
      end
      if (mode == 1 && cyc == 15)
        chk("stall_credit_limit", 32'(n_rden), 32'(n_beats - beats0 + SKID_DEPTH));
      step();
      cyc++;
    end
    bus.start = 1'b0; bus.rdy = 1'b1; bus.m_ready = 1'b1;
    chk("burst_finished", 32'(n_done), 32'd1);
    #1;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    step();
    step();
    chk("done_once", 32'(n_done), 32'd1);
    chk("rden_count", 32'(n_rden), 32'(len));
    chk("all_beats_out", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_pulse();
    #2;
    rst = 1'b0;
    #1;
    chk_quiet("reset_outputs");
    chk("reset_m_data", 32'(bus.m_data), 32'h0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge rclk);
    rst = 1'b1;
    @(negedge rclk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_rden = 0; n_done = 0; n_beats = 0;
    prev_stall = 1'b0; prev_data = 16'h0; last_beat = 16'h0;
    bus.start = 1'b0; bus.len = 16'h0; bus.rdy = 1'b1; bus.m_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge rclk);
    #1;
    chk_quiet("por_outputs");
    chk("por_m_data", 32'(bus.m_data), 32'h0);
    rst = 1'b1;
    @(negedge rclk);

    // Cycle-exact basic burst, len=4, samples 0x0100..0x0103.
    tbl.push_back('{1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    for (int c = 1; c <= 3; c++)
      tbl.push_back('{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100});
    for (int c = 5; c <= 7; c++)
      tbl.push_back('{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100 + 16'(c - 4)});
`ifdef READOUT_CHKSUM_EN
    tbl.push_back('{1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0406});
`endif
    tbl.push_back('{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    load_burst(4, 0);
    foreach (tbl[i]) begin
      bus.start = tbl[i].start;
      bus.len   = tbl[i].len;
      #1;
      chk($sformatf("tbl%0d_ctl", i),
          {28'd0, bus.rden, bus.m_valid, bus.busy, bus.done},
          {28'd0, tbl[i].rden, tbl[i].m_valid, tbl[i].busy, tbl[i].done});
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), 32'(bus.m_data), 32'(tbl[i].m_data));
      observe();
      @(negedge rclk);
    end
    chk("tbl_all_beats_out", 32'(exp_q.size()), 32'd0);

    // Reset while idle, then no activity without start.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_quiet("idle_no_activity");
      @(negedge rclk);
    end

    // start with len=0 is ignored.
    bus.start = 1'b1; bus.len = 16'd0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_quiet("len0_ignored");
      @(negedge rclk);
    end

    run_burst(16, 1);
    run_burst(8, 2);
    run_burst(3, 5);
`ifdef READOUT_CHKSUM_EN
    chk("chksum_beat", 32'(last_beat), 32'h0011);
`else
    chk("last_sample", 32'(last_beat), 32'h0010);
`endif

    // Reset in the middle of a burst, then a clean burst.
    load_burst(10, 3);
    bus.start = 1'b1; bus.len = 16'd10;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    reset_pulse();
    run_burst(5, 0);

    for (int k = 0; k < 20; k++) run_burst(int'($urandom_range(1, 40)), 3 + (k % 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
